// File: rtl/ps2_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_cmd_decoder_if
//  Purpose  : Bundles the PS/2 byte input stream and the decoded command
//             outputs of ps2_cmd_decoder.
//  Ports    : master - drives rx_tick/rx_data, observes decoder outputs
//             slave  - decoder side
//    rx_tick      1           one-cycle strobe, rx_data valid
//    rx_data      8           scancode byte (set 2)
//    value_bcd    4*N_DIGITS  last committed value, digit 0 in [3:0]
//    value_valid  1           pulse when value_bcd updates
//    flags        N_FLAGS     toggle state per function key
//    soft_reset   1           pulse on Esc
//    busy         1           entry buffer non-empty
//    err          1           pulse on rejected action
//  Revision : 1.0 - initial release
// ============================================================================
interface ps2_cmd_decoder_if #(
  parameter int N_DIGITS = 2,
  parameter int N_FLAGS  = 3
);
  logic                    rx_tick;
  logic [7:0]              rx_data;
  logic [4*N_DIGITS-1:0]   value_bcd;
  logic                    value_valid;
  logic [N_FLAGS-1:0]      flags;
  logic                    soft_reset;
  logic                    busy;
  logic                    err;

  modport master (
    output rx_tick, rx_data,
    input  value_bcd, value_valid, flags, soft_reset, busy, err
  );

  modport slave (
    input  rx_tick, rx_data,
    output value_bcd, value_valid, flags, soft_reset, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/ps2_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_cmd_decoder
//  Purpose  : Filters PS/2 set-2 break (F0) and extended (E0) prefixes and
//             interprets make codes as a decimal entry editor: digits fill an
//             N_DIGITS BCD buffer, Enter commits, Backspace/Esc edit, and
//             F1..F8 toggle flags.
//  Ports    : CLK    - system clock
//             reset  - synchronous active-high reset
//             bus    - ps2_cmd_decoder_if.slave (byte input, decoded outputs)
//  Options  : PS2_TIMEOUT_EN - when defined, a partial entry left idle for
//             TIMEOUT_CYC cycles is abandoned with an err pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_cmd_decoder #(
  parameter int N_DIGITS    = 2,
  parameter int N_FLAGS     = 3
`ifdef PS2_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 50_000_000
`endif
) (
  input  logic               CLK,
  input  logic               reset,
  ps2_cmd_decoder_if.slave   bus
);

  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_BRK     = 2'd1;
  localparam logic [1:0] c_ST_EXT     = 2'd2;
  localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

  localparam logic [7:0] c_BREAK = 8'hF0;
  localparam logic [7:0] c_EXTND = 8'hE0;
  localparam logic [7:0] c_ENTER = 8'h5A;
  localparam logic [7:0] c_BKSP  = 8'h66;
  localparam logic [7:0] c_ESC   = 8'h76;

  logic [1:0]         state_q, state_d;
  logic [BW-1:0]      buf_q, buf_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      value_q, value_d;
  logic               valid_q, valid_d;
  logic [N_FLAGS-1:0] flags_q, flags_d;
  logic               soft_q, soft_d;
  logic               err_q, err_d;
  logic               w_timeout;

  // Set-2 digit make codes -> BCD value; bit 4 flags a hit.
  function automatic logic [4:0] digit_of(input logic [7:0] b);
    case (b)
      8'h45: digit_of = 5'h10;
      8'h16: digit_of = 5'h11;
      8'h1E: digit_of = 5'h12;
      8'h26: digit_of = 5'h13;
      8'h25: digit_of = 5'h14;
      8'h2E: digit_of = 5'h15;
      8'h36: digit_of = 5'h16;
      8'h3D: digit_of = 5'h17;
      8'h3E: digit_of = 5'h18;
      8'h46: digit_of = 5'h19;
      default: digit_of = 5'h00;
    endcase
  endfunction

  // F1..F8 make codes -> flag index; bit 3 flags a hit.
  function automatic logic [3:0] fkey_of(input logic [7:0] b);
    case (b)
      8'h05: fkey_of = 4'h8;
      8'h06: fkey_of = 4'h9;
      8'h04: fkey_of = 4'hA;
      8'h0C: fkey_of = 4'hB;
      8'h03: fkey_of = 4'hC;
      8'h0B: fkey_of = 4'hD;
      8'h83: fkey_of = 4'hE;
      8'h0A: fkey_of = 4'hF;
      default: fkey_of = 4'h0;
    endcase
  endfunction

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] c_IDLE_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] idle_q, idle_d;

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign w_timeout = !bus.rx_tick && (cnt_q != '0) && (idle_q == c_IDLE_LAST);

  always_comb begin
    idle_d = idle_q + TW'(1);
    if (bus.rx_tick || (cnt_q == '0) || w_timeout) begin
      idle_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (reset) state_q <= c_ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: prefix tracking only, advancing on rx_tick.
  always_comb begin
    state_d = state_q;
    if (w_timeout) begin
      state_d = c_ST_IDLE;
    end else if (bus.rx_tick) begin
      case (state_q)
        c_ST_IDLE: begin
          if (bus.rx_data == c_BREAK)      state_d = c_ST_BRK;
          else if (bus.rx_data == c_EXTND) state_d = c_ST_EXT;
          else                             state_d = c_ST_IDLE;
        end
        c_ST_BRK:  state_d = (bus.rx_data == c_BREAK) ? c_ST_BRK : c_ST_IDLE;
        c_ST_EXT:  state_d = (bus.rx_data == c_BREAK) ? c_ST_EXT_BRK : c_ST_IDLE;
        default:   state_d = c_ST_IDLE;
      endcase
    end
  end

  // Output / datapath logic: one action at most per received byte.
  always_comb begin
    logic       make, enter;
    logic [4:0] dig;
    logic [3:0] fk;

    buf_d   = buf_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    flags_d = flags_q;
    valid_d = 1'b0;
    soft_d  = 1'b0;
    err_d   = 1'b0;

    make  = bus.rx_tick && (state_q == c_ST_IDLE) &&
            (bus.rx_data != c_BREAK) && (bus.rx_data != c_EXTND);
    enter = (make && (bus.rx_data == c_ENTER)) ||
            (bus.rx_tick && (state_q == c_ST_EXT) && (bus.rx_data == c_ENTER));
    dig   = digit_of(bus.rx_data);
    fk    = fkey_of(bus.rx_data);

    if (w_timeout) begin
      buf_d = '0;
      cnt_d = '0;
      err_d = 1'b1;
    end else if (enter) begin
      if (cnt_q != '0) begin
        value_d = buf_q;
        valid_d = 1'b1;
        buf_d   = '0;
        cnt_d   = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (make) begin
      if (dig[4]) begin
        if (cnt_q < CW'(N_DIGITS)) begin
          buf_d = (buf_q << 4) | BW'(dig[3:0]);
          cnt_d = cnt_q + CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.rx_data == c_BKSP) begin
        if (cnt_q != '0) begin
          buf_d = buf_q >> 4;
          cnt_d = cnt_q - CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.rx_data == c_ESC) begin
        buf_d  = '0;
        cnt_d  = '0;
        soft_d = 1'b1;
      end else if (fk[3]) begin
        // Keys beyond the configured flag count simply match no index.
        for (int k = 0; k < N_FLAGS; k++) begin
          if (fk[2:0] == k[2:0]) flags_d[k] = ~flags_q[k];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      flags_q <= '0;
      soft_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
      soft_q  <= soft_d;
      err_q   <= err_d;
    end
  end

  assign bus.value_bcd   = value_q;
  assign bus.value_valid = valid_q;
  assign bus.flags       = flags_q;
  assign bus.soft_reset  = soft_q;
  assign bus.busy        = (cnt_q != '0);
  assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_cmd_decoder
//  Purpose  : Directed self-checking bench for ps2_cmd_decoder (N_DIGITS=2,
//             N_FLAGS=3). With PS2_TIMEOUT_EN defined, TIMEOUT_CYC=100 and
//             the idle-timeout sequences are added.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_cmd_decoder;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  int   valid_seen;
  int   err_seen;

  ps2_cmd_decoder_if #(.N_DIGITS(2), .N_FLAGS(3)) bus ();

  ps2_cmd_decoder #(
    .N_DIGITS(2),
    .N_FLAGS(3)
`ifdef PS2_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (bus.value_valid) valid_seen++;
    if (bus.err)         err_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns on the following negedge, where
  // the registered effects of that byte are visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_tick = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_tick = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".value"}, 32'(bus.value_bcd), 32'h0);
    chk({tag, ".pulses"}, {29'h0, bus.value_valid, bus.soft_reset, bus.err}, 32'h0);
    chk({tag, ".flags"}, 32'(bus.flags), 32'h0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int v0, e0;
    n_vec = 0; n_bad = 0; valid_seen = 0; err_seen = 0;
    rst = 1'b1;
    bus.rx_tick = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: "23" typed with break codes, committed with Enter.
    v0 = valid_seen; e0 = err_seen;
    send(8'h1E);
    chk("t1.busy_after_digit", 32'(bus.busy), 32'h1);
    send(8'hF0); send(8'h1E); send(8'h26); send(8'hF0); send(8'h26);
    send(8'h5A);
    chk("t1.value", 32'(bus.value_bcd), 32'h23);
    chk("t1.valid_now", 32'(bus.value_valid), 32'h1);
    chk("t1.busy_after_enter", 32'(bus.busy), 32'h0);
    send(8'hF0); send(8'h5A);
    chk("t1.valid_count", 32'(valid_seen - v0), 32'h1);
    chk("t1.err_count", 32'(err_seen - e0), 32'h0);

    // 2: overflow, backspace, extended Enter.
    send(8'h16); send(8'h1E);
    chk("t2.no_err_yet", 32'(bus.err), 32'h0);
    send(8'h26);
    chk("t2.overflow_err", 32'(bus.err), 32'h1);
    send(8'h66);
    chk("t2.busy_after_bksp", 32'(bus.busy), 32'h1);
    send(8'hE0); send(8'h5A);
    chk("t2.value", 32'(bus.value_bcd), 32'h01);
    chk("t2.valid", 32'(bus.value_valid), 32'h1);

    // 3: Enter with empty buffer, then flag toggles.
    send(8'h5A);
    chk("t3.empty_enter_err", 32'(bus.err), 32'h1);
    chk("t3.empty_enter_valid", 32'(bus.value_valid), 32'h0);
    chk("t3.value_held", 32'(bus.value_bcd), 32'h01);
    send(8'h05);
    chk("t3.flags_f1_on", 32'(bus.flags), 32'h1);
    send(8'hF0); send(8'h05);
    chk("t3.flags_break_ignored", 32'(bus.flags), 32'h1);
    send(8'h05);
    chk("t3.flags_f1_off", 32'(bus.flags), 32'h0);
    send(8'h06); send(8'h04);
    chk("t3.flags_f2_f3", 32'(bus.flags), 32'h6);
    e0 = err_seen;
    send(8'h0C);
    chk("t3.f4_ignored", 32'(bus.flags), 32'h6);
    chk("t3.f4_no_err", 32'(err_seen - e0), 32'h0);
    send(8'h66);
    chk("t3.empty_bksp_err", 32'(bus.err), 32'h1);

    // 4: extended break of Enter does not commit; Esc clears.
    v0 = valid_seen;
    send(8'h16); send(8'hE0); send(8'hF0); send(8'h5A);
    chk("t4.no_commit", 32'(valid_seen - v0), 32'h0);
    chk("t4.busy_kept", 32'(bus.busy), 32'h1);
    send(8'h76);
    chk("t4.soft_reset", 32'(bus.soft_reset), 32'h1);
    chk("t4.busy_cleared", 32'(bus.busy), 32'h0);
    chk("t4.value_kept", 32'(bus.value_bcd), 32'h01);
    chk("t4.flags_kept", 32'(bus.flags), 32'h6);

    // 6: reset right after a break prefix drops the prefix.
    send(8'hF0);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("t6.during_reset");
    rst = 1'b0;
    send(8'h16);
    chk("t6.digit_accepted", 32'(bus.busy), 32'h1);
    send(8'h5A);
    chk("t6.value", 32'(bus.value_bcd), 32'h01);

`ifdef PS2_TIMEOUT_EN
    // 5: idle timeout abandons a partial entry.
    send(8'h16);
    repeat (99) @(negedge clk);
    chk("t5.before_expiry_busy", 32'(bus.busy), 32'h1);
    chk("t5.before_expiry_err", 32'(bus.err), 32'h0);
    @(negedge clk);
    chk("t5.expiry_err", 32'(bus.err), 32'h1);
    chk("t5.expiry_busy", 32'(bus.busy), 32'h0);
    // A byte landing in the expiry cycle wins.
    send(8'h16);
    repeat (99) @(negedge clk);
    e0 = err_seen;
    send(8'h16);
    chk("t5.race_no_err", 32'(err_seen - e0), 32'h0);
    chk("t5.race_busy", 32'(bus.busy), 32'h1);
    send(8'h5A);
    chk("t5.race_value", 32'(bus.value_bcd), 32'h11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
